signed_sum_accumulator: RTL

Downstream consumer of the 4-input signed 4-bit adder. It accepts that adder's `sum`/`overflow` result as a stream of beats and accumulates a fixed block of N_SAMPLES beats into a wider saturating signed total. It also counts how many beats arrived with the adder's overflow flag set, then presents the block result over a valid/ready handshake.

---
 rtl/signed_sum_accumulator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/signed_sum_accumulator.sv
// signed_sum_accumulator: accumulates N_SAMPLES signed 4-bit adder results
// into a saturating ACC_W-bit total, counts beats flagged with adder
// overflow, and hands the block result downstream over valid/ready.
module signed_sum_accumulator #(
  parameter int unsigned ACC_W     = 6,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_sat,
  output logic [3:0]       out_ovf_count
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);

  // Clamp limits expressed at the widened sum width.
  localparam logic signed [SUM_W-1:0] MAX_V = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [3:0]       r_ovf_cnt;
  logic [CNT_W-1:0] r_cnt;

  logic signed [SUM_W-1:0] w_acc_ext;
  logic signed [SUM_W-1:0] w_in_ext;
  logic signed [SUM_W-1:0] w_wide;
  logic        [ACC_W-1:0] w_next;
  logic                    w_clamped;
  logic                    w_accept;

  // Widened signed add of the incoming beat, then clamp to the ACC_W range.
  always_comb begin
    w_acc_ext = {r_acc[ACC_W-1], r_acc};
    w_in_ext  = {{(SUM_W-4){in_sum[3]}}, in_sum};
    w_wide    = w_acc_ext + w_in_ext;
    w_next    = w_wide[ACC_W-1:0];
    w_clamped = 1'b0;
    if (w_wide > MAX_V) begin
      w_next    = MAX_V[ACC_W-1:0];
      w_clamped = 1'b1;
    end else if (w_wide < MIN_V) begin
      w_next    = MIN_V[ACC_W-1:0];
      w_clamped = 1'b1;
    end
    w_accept = in_valid && r_in_ready;
  end

  // Block FSM: accumulate beats in ACCUM, present the result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_ovf_cnt   <= '0;
      r_cnt       <= '0;
    end else if (clear) begin
      r_state     <= ST_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_ovf_cnt   <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_acc <= w_next;
            if (w_clamped) begin
              r_sat <= 1'b1;
            end
            if (in_overflow && (r_ovf_cnt != 4'hF)) begin
              r_ovf_cnt <= r_ovf_cnt + 4'd1;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(N_SAMPLES - 1)) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_ovf_cnt   <= '0;
            r_cnt       <= '0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_total     = r_acc;
  assign out_sat       = r_sat;
  assign out_ovf_count = r_ovf_cnt;

endmodule
